// File: rtl/sd_kin_sequencer.sv
// Tuning-word scheduler for the sigma-delta tone generator: walks a (kin, dwell) table,
// ramping kout linearly to each entry's kin and holding it for the entry's dwell.
module sd_kin_sequencer #(
    parameter int BITWIDTH  = 40,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int DWELL_W   = 24,
    parameter int RAMP_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [BITWIDTH-1:0] cfg_kin,
    input  logic [DWELL_W-1:0]  cfg_dwell,
    input  logic [ADDR_W-1:0]   last_idx,
    input  logic                loop_en,
    input  logic                start,
    input  logic                stop,
    output logic [BITWIDTH-1:0] kout,
    output logic                kout_upd,
    output logic [ADDR_W-1:0]   idx,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RAMP,
        S_DWELL,
        S_DONE
    } state_t;

    localparam int                RC_W      = RAMP_LOG2 + 1;
    localparam logic [RC_W-1:0]   RAMP_LAST = RC_W'((2 ** RAMP_LOG2) - 1);
    localparam logic [ADDR_W-1:0] IDX_MAX   = ADDR_W'(DEPTH - 1);

    logic [BITWIDTH-1:0] kin_mem   [DEPTH];
    logic [DWELL_W-1:0]  dwell_mem [DEPTH];

    state_t                state, state_n;
    logic [ADDR_W-1:0]     idx_n;
    logic [BITWIDTH-1:0]   kout_n, tgt, tgt_n, step, step_n;
    logic [RC_W-1:0]       ramp_cnt, ramp_cnt_n;
    logic [DWELL_W-1:0]    dwell_cnt, dwell_cnt_n;
    logic signed [BITWIDTH:0] diff;

    // The table has no reset so it survives a sequencer reset; writes are accepted in any state.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            kin_mem[cfg_addr]   <= cfg_kin;
            dwell_mem[cfg_addr] <= cfg_dwell;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        kout_n      = kout;
        tgt_n       = tgt;
        step_n      = step;
        ramp_cnt_n  = ramp_cnt;
        dwell_cnt_n = dwell_cnt;
        // One extra bit keeps the sign of the distance for downward ramps.
        diff = $signed({1'b0, kin_mem[idx]}) - $signed({1'b0, kout});

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_n = S_LOAD;
                    idx_n   = '0;
                end
            end
            S_LOAD: begin
                tgt_n       = kin_mem[idx];
                dwell_cnt_n = (dwell_mem[idx] == '0) ? DWELL_W'(1) : dwell_mem[idx];
                step_n      = BITWIDTH'(diff >>> RAMP_LOG2);
                ramp_cnt_n  = '0;
                state_n     = S_RAMP;
            end
            S_RAMP: begin
                // The last ramp cycle snaps to the target to absorb shift truncation.
                if (ramp_cnt == RAMP_LAST) begin
                    kout_n  = tgt;
                    state_n = S_DWELL;
                end else begin
                    kout_n     = kout + step;
                    ramp_cnt_n = ramp_cnt + RC_W'(1);
                end
            end
            S_DWELL: begin
                if (dwell_cnt <= DWELL_W'(1)) begin
                    if (idx != last_idx) begin
                        idx_n   = (idx == IDX_MAX) ? '0 : idx + ADDR_W'(1);
                        state_n = S_LOAD;
                    end else if (loop_en) begin
                        idx_n   = '0;
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    dwell_cnt_n = dwell_cnt - DWELL_W'(1);
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // stop overrides every transition and freezes kout where it is.
        if (stop && state != S_IDLE) begin
            state_n = S_IDLE;
            idx_n   = '0;
            kout_n  = kout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            kout      <= '0;
            kout_upd  <= 1'b0;
            tgt       <= '0;
            step      <= '0;
            ramp_cnt  <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            kout      <= kout_n;
            kout_upd  <= (kout_n != kout);
            tgt       <= tgt_n;
            step      <= step_n;
            ramp_cnt  <= ramp_cnt_n;
            dwell_cnt <= dwell_cnt_n;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule
